sram_port_arbiter: RTL and testbench

//  Shares the 1RW port (port 0) of one OpenRAM macro (32x256 or 32x512) between two requesters:
//  A = Wishbone-side path from user_project, B = on-chip test/BIST requester.

---
 rtl/sram_port_arbiter_if.sv | 51 +++++
 rtl/sram_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Bundle of requester A (Wishbone side), requester B (test/BIST side) and OpenRAM port-0 signals.
// Handshake: stb/req is held with a stable command until the one-cycle ack; the arbiter samples only while idle.
interface sram_port_arbiter_if #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int WMASK_W = 4
);
  logic               a_stb_i;
  logic               a_we_i;
  logic [WMASK_W-1:0] a_sel_i;
  logic [ADDR_W-1:0]  a_adr_i;
  logic [DATA_W-1:0]  a_dat_i;
  logic               a_ack_o;
  logic [DATA_W-1:0]  a_dat_o;

  logic               b_req_i;
  logic               b_we_i;
  logic [WMASK_W-1:0] b_wmask_i;
  logic [ADDR_W-1:0]  b_addr_i;
  logic [DATA_W-1:0]  b_wdata_i;
  logic               b_ack_o;
  logic [DATA_W-1:0]  b_rdata_o;

  logic               sram_csb0_o;
  logic               sram_web0_o;
  logic [WMASK_W-1:0] sram_wmask0_o;
  logic [ADDR_W-1:0]  sram_addr0_o;
  logic [DATA_W-1:0]  sram_din0_o;
  logic [DATA_W-1:0]  sram_dout0_i;
  logic               busy_o;

  modport slave (
    input  a_stb_i, a_we_i, a_sel_i, a_adr_i, a_dat_i,
    output a_ack_o, a_dat_o,
    input  b_req_i, b_we_i, b_wmask_i, b_addr_i, b_wdata_i,
    output b_ack_o, b_rdata_o,
    output sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o,
    input  sram_dout0_i,
    output busy_o
  );

  modport master (
    output a_stb_i, a_we_i, a_sel_i, a_adr_i, a_dat_i,
    input  a_ack_o, a_dat_o,
    output b_req_i, b_we_i, b_wmask_i, b_addr_i, b_wdata_i,
    input  b_ack_o, b_rdata_o,
    input  sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o,
    output sram_dout0_i,
    input  busy_o
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for the 1RW port of an OpenRAM macro, one access in flight, registered macro outputs.
// Optional SRAM_ARB_RR_EN: round-robin tie-break; otherwise A has fixed priority.
module sram_port_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int WMASK_W  = 4,
  parameter int READ_LAT = 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  sram_port_arbiter_if.slave   bus,
  output logic [1:0]           dbg_state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;
  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               win_b_q, win_b_d;
  logic               we_q, we_d;
  logic               csb_q, csb_d;
  logic               web_q, web_d;
  logic [WMASK_W-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic               a_ack_q, a_ack_d;
  logic               b_ack_q, b_ack_d;
  logic [DATA_W-1:0]  a_dat_q, a_dat_d;
  logic [DATA_W-1:0]  b_dat_q, b_dat_d;
  logic               grant, grant_b;
`ifdef SRAM_ARB_RR_EN
  logic               last_b_q, last_b_d;
`endif

  // grant_b is only meaningful while grant is high
  always_comb begin
    grant = bus.a_stb_i | bus.b_req_i;
`ifdef SRAM_ARB_RR_EN
    grant_b = bus.b_req_i & (~bus.a_stb_i | ~last_b_q);
`else
    grant_b = ~bus.a_stb_i;
`endif
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      win_b_q  <= 1'b0;
      we_q     <= 1'b0;
      csb_q    <= 1'b1;
      web_q    <= 1'b1;
      mask_q   <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      a_dat_q  <= '0;
      b_dat_q  <= '0;
`ifdef SRAM_ARB_RR_EN
      last_b_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_b_q  <= win_b_d;
      we_q     <= we_d;
      csb_q    <= csb_d;
      web_q    <= web_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      a_dat_q  <= a_dat_d;
      b_dat_q  <= b_dat_d;
`ifdef SRAM_ARB_RR_EN
      last_b_q <= last_b_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_b_d  = win_b_q;
    we_d     = we_q;
`ifdef SRAM_ARB_RR_EN
    last_b_d = last_b_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d  = ISSUE;
          win_b_d  = grant_b;
          we_d     = grant_b ? bus.b_we_i : bus.a_we_i;
`ifdef SRAM_ARB_RR_EN
          last_b_d = grant_b;
`endif
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(READ_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Macro command is loaded while leaving IDLE so csb0 is low for exactly the ISSUE cycle
  always_comb begin
    csb_d   = 1'b1;
    web_d   = 1'b1;
    mask_d  = mask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    a_dat_d = a_dat_q;
    b_dat_d = b_dat_q;
    if (state_q == IDLE && grant) begin
      csb_d = 1'b0;
      if (grant_b) begin
        web_d  = ~bus.b_we_i;
        mask_d = bus.b_we_i ? bus.b_wmask_i : '0;
        addr_d = bus.b_addr_i;
        din_d  = bus.b_wdata_i;
      end else begin
        web_d  = ~bus.a_we_i;
        mask_d = bus.a_we_i ? bus.a_sel_i : '0;
        addr_d = bus.a_adr_i;
        din_d  = bus.a_dat_i;
      end
    end
    if (state_q == WAIT && cnt_q == '0) begin
      if (win_b_q) b_dat_d = bus.sram_dout0_i;
      else         a_dat_d = bus.sram_dout0_i;
    end
    if (state_d == RESP) begin
      a_ack_d = ~win_b_q;
      b_ack_d = win_b_q;
    end
  end

  assign bus.sram_csb0_o   = csb_q;
  assign bus.sram_web0_o   = web_q;
  assign bus.sram_wmask0_o = mask_q;
  assign bus.sram_addr0_o  = addr_q;
  assign bus.sram_din0_o   = din_q;
  assign bus.a_ack_o       = a_ack_q;
  assign bus.a_dat_o       = a_dat_q;
  assign bus.b_ack_o       = b_ack_q;
  assign bus.b_rdata_o     = b_dat_q;
  assign bus.busy_o        = (state_q != IDLE);
  assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: OpenRAM port model, transaction-level reference with per-cycle compare, directed tests.
module tb_sram_port_arbiter;
  localparam int ADDR_W = 9, DATA_W = 32, WMASK_W = 4, READ_LAT = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         n_cmp = 0;
  int         n_err = 0;

  sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WMASK_W(WMASK_W)) bus ();

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WMASK_W(WMASK_W), .READ_LAT(READ_LAT)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- OpenRAM port-0 model ----------------
  logic [DATA_W-1:0] sram_mem [int];
  always @(posedge clk) begin
    logic [DATA_W-1:0] w;
    if (!bus.sram_csb0_o) begin
      w = sram_mem.exists(int'(bus.sram_addr0_o)) ? sram_mem[int'(bus.sram_addr0_o)] : '0;
      if (!bus.sram_web0_o) begin
        for (int i = 0; i < WMASK_W; i++)
          if (bus.sram_wmask0_o[i]) w[8*i +: 8] = bus.sram_din0_o[8*i +: 8];
        sram_mem[int'(bus.sram_addr0_o)] = w;
      end else begin
        bus.sram_dout0_i <= w;
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  logic [DATA_W-1:0]  ref_mem [int];
  logic [DATA_W-1:0]  exp_q [$];
  int                 cyc = 0, issue_cyc = -1, ack_cyc = -1;
  logic               win_b = 1'b0, t_we = 1'b0;
  logic [ADDR_W-1:0]  t_addr = '0, hold_addr = '0;
  logic [WMASK_W-1:0] t_mask = '0, hold_mask = '0;
  logic [DATA_W-1:0]  t_wdata = '0;
`ifdef SRAM_ARB_RR_EN
  logic               last_b = 1'b1;
`endif

  always @(posedge clk) begin
    logic [DATA_W-1:0] w, e;
    if (!rst_n) begin
      issue_cyc = -1;
      ack_cyc   = -1;
      hold_addr = '0;
      hold_mask = '0;
      exp_q.delete();
`ifdef SRAM_ARB_RR_EN
      last_b = 1'b1;
`endif
    end else if (cyc > ack_cyc && (bus.a_stb_i || bus.b_req_i)) begin
`ifdef SRAM_ARB_RR_EN
      win_b  = (bus.a_stb_i && bus.b_req_i) ? !last_b : bus.b_req_i;
      last_b = win_b;
`else
      win_b  = !bus.a_stb_i;
`endif
      t_we    = win_b ? bus.b_we_i : bus.a_we_i;
      t_addr  = win_b ? bus.b_addr_i : bus.a_adr_i;
      t_mask  = win_b ? bus.b_wmask_i : bus.a_sel_i;
      t_wdata = win_b ? bus.b_wdata_i : bus.a_dat_i;
      issue_cyc = cyc + 1;
      ack_cyc   = cyc + 2 + (t_we ? 0 : READ_LAT);
      w = ref_mem.exists(int'(t_addr)) ? ref_mem[int'(t_addr)] : '0;
      if (t_we) begin
        for (int i = 0; i < WMASK_W; i++)
          if (t_mask[i]) w[8*i +: 8] = t_wdata[8*i +: 8];
        ref_mem[int'(t_addr)] = w;
      end else begin
        exp_q.push_back(w);
      end
    end
    cyc++;
    #1;
    if (rst_n) begin
      if (cyc == issue_cyc) begin
        hold_addr = t_addr;
        hold_mask = t_we ? t_mask : '0;
      end
      chk("csb0", bus.sram_csb0_o, cyc != issue_cyc);
      chk("web0", bus.sram_web0_o, (cyc == issue_cyc) ? !t_we : 1'b1);
      chk("addr0", bus.sram_addr0_o, hold_addr);
      chk("wmask0", bus.sram_wmask0_o, hold_mask);
      if (cyc == issue_cyc && t_we) chk("din0", bus.sram_din0_o, t_wdata);
      chk("busy", bus.busy_o, cyc >= issue_cyc && cyc <= ack_cyc);
      chk("a_ack", bus.a_ack_o, cyc == ack_cyc && !win_b);
      chk("b_ack", bus.b_ack_o, cyc == ack_cyc && win_b);
      if (cyc == ack_cyc && !t_we) begin
        if (exp_q.size() == 0) chk("exp_q_empty", 1, 0);
        else begin
          e = exp_q.pop_front();
          if (win_b) chk("b_rdata", bus.b_rdata_o, e);
          else       chk("a_dat", bus.a_dat_o, e);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_idle();
    bus.a_stb_i = 0; bus.a_we_i = 0; bus.a_sel_i = '0; bus.a_adr_i = '0; bus.a_dat_i = '0;
    bus.b_req_i = 0; bus.b_we_i = 0; bus.b_wmask_i = '0; bus.b_addr_i = '0; bus.b_wdata_i = '0;
  endtask

  task automatic xfer(input bit is_b, input bit we, input logic [ADDR_W-1:0] adr,
                      input logic [DATA_W-1:0] dat, input logic [WMASK_W-1:0] msk,
                      output logic [DATA_W-1:0] rdat);
    bit got = 0;
    rdat = '0;
    @(negedge clk);
    if (is_b) begin
      bus.b_req_i = 1; bus.b_we_i = we; bus.b_addr_i = adr; bus.b_wdata_i = dat; bus.b_wmask_i = msk;
    end else begin
      bus.a_stb_i = 1; bus.a_we_i = we; bus.a_adr_i = adr; bus.a_dat_i = dat; bus.a_sel_i = msk;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (is_b && bus.b_ack_o) begin got = 1; rdat = bus.b_rdata_o; end
      if (!is_b && bus.a_ack_o) begin got = 1; rdat = bus.a_dat_o; end
    end
    if (!got) chk("ack_timeout", 0, 1);
    bus.a_stb_i = 0;
    bus.b_req_i = 0;
  endtask

  initial begin
    logic [DATA_W-1:0] r;
    bit grants[$];
    bit done;
    drive_idle();

    // 1: reset with a pending A request
    bus.a_stb_i = 1;
    repeat (3) @(negedge clk);
    chk("rst_csb0", bus.sram_csb0_o, 1);
    chk("rst_web0", bus.sram_web0_o, 1);
    chk("rst_a_ack", bus.a_ack_o, 0);
    chk("rst_b_ack", bus.b_ack_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_a_dat", bus.a_dat_o, 0);
    chk("rst_addr0", bus.sram_addr0_o, 0);
    bus.a_stb_i = 0;
    rst_n = 1;

    // 2: A write, exact cycle timing
    @(negedge clk);
    bus.a_stb_i = 1; bus.a_we_i = 1; bus.a_adr_i = 9'h005; bus.a_dat_i = 32'hDEADBEEF; bus.a_sel_i = 4'b0101;
    @(negedge clk);
    chk("wr_t1_csb0", bus.sram_csb0_o, 0);
    chk("wr_t1_web0", bus.sram_web0_o, 0);
    chk("wr_t1_wmask0", bus.sram_wmask0_o, 4'b0101);
    chk("wr_t1_addr0", bus.sram_addr0_o, 9'h005);
    chk("wr_t1_ack", bus.a_ack_o, 0);
    @(negedge clk);
    chk("wr_t2_ack", bus.a_ack_o, 1);
    bus.a_stb_i = 0;

    // 3: A read of the half-written word
    @(negedge clk);
    bus.a_stb_i = 1; bus.a_we_i = 0; bus.a_adr_i = 9'h005;
    @(negedge clk);
    chk("rd_t1_csb0", bus.sram_csb0_o, 0);
    chk("rd_t1_web0", bus.sram_web0_o, 1);
    @(negedge clk);
    chk("rd_t2_ack", bus.a_ack_o, 0);
    @(negedge clk);
    chk("rd_t3_ack", bus.a_ack_o, 1);
    chk("rd_t3_dat", bus.a_dat_o, 32'h00AD00EF);
    bus.a_stb_i = 0;

    // 4: both requesters read continuously
    xfer(0, 1, 9'h010, 32'h11111111, 4'hF, r);
    xfer(1, 1, 9'h020, 32'h22222222, 4'hF, r);
    @(negedge clk);
    bus.a_stb_i = 1; bus.a_we_i = 0; bus.a_adr_i = 9'h010;
    bus.b_req_i = 1; bus.b_we_i = 0; bus.b_addr_i = 9'h020;
    repeat (40) begin
      @(negedge clk);
      if (bus.a_ack_o) grants.push_back(0);
      if (bus.b_ack_o) grants.push_back(1);
    end
    bus.a_stb_i = 0; bus.b_req_i = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = !bus.busy_o;
    end
    chk("drain_idle", done, 1);
    chk("grant_count_ge4", grants.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_RR_EN
      chk($sformatf("grant_%0d", i), (grants.size() > i) ? grants[i] : 1'bx, i % 2);
`else
      chk($sformatf("grant_%0d", i), (grants.size() > i) ? grants[i] : 1'bx, 0);
`endif
    end

    // 5: top address, partial overwrite, no wrap into 0x0FF
    xfer(1, 1, 9'h1FF, 32'hCAFEF00D, 4'hF, r);
    xfer(1, 0, 9'h1FF, '0, '0, r);
    chk("b_max_rd", r, 32'hCAFEF00D);
    xfer(0, 1, 9'h1FF, 32'h12345678, 4'b1000, r);
    xfer(1, 0, 9'h1FF, '0, '0, r);
    chk("b_max_partial", r, 32'h12FEF00D);
    xfer(0, 0, 9'h0FF, '0, '0, r);
    chk("no_wrap", r, 32'h0);

    // 6: reset during WAIT of a B read
    @(negedge clk);
    bus.b_req_i = 1; bus.b_we_i = 0; bus.b_addr_i = 9'h005;
    @(negedge clk);
    @(negedge clk);
    chk("in_wait", dbg_state, 2'd2);
    rst_n = 0;
    bus.b_req_i = 0;
    #1;
    chk("abort_csb0", bus.sram_csb0_o, 1);
    chk("abort_busy", bus.busy_o, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_b_ack", bus.b_ack_o, 0);
    end
    rst_n = 1;
    xfer(0, 0, 9'h005, '0, '0, r);
    chk("post_rst_rd", r, 32'h00AD00EF);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
